// File: rtl/card_pkg.sv
// rtl/card_pkg.sv - shared card types, deck constants and blackjack value helper
//
// Purpose : types and helpers shared by the shoe and by the score/display logic.
// Contents: card_t {suit, rank0}, shoe FSM state type, deck size constants,
//           bj_value() mapping a zero-based rank to its blackjack value.
package card_pkg;

  localparam int DECK_SIZE = 52;
  localparam int RANKS     = 13;
  localparam int SUITS     = 4;

  // rank holds rank0: 0=ace .. 12=king
  typedef struct packed {
    logic [1:0] suit;
    logic [3:0] rank;
  } card_t;

  typedef enum logic [2:0] {
    ST_FILL,
    ST_READY,
    ST_DEAL,
    ST_SH_PICK,
    ST_SH_SWAP
  } shoe_state_t;

  // ace counts 1; ten, jack, queen and king all count 10
  function automatic logic [3:0] bj_value(input logic [3:0] rank);
    return (rank >= 4'd9) ? 4'd10 : rank + 4'd1;
  endfunction

endpackage

// File: rtl/lfsr_rng.sv
// rtl/lfsr_rng.sv - maximal-length Galois LFSR with seed load and step enable
//
// Purpose : pseudo-random source shared by the random blocks.
// Ports   : clk      in  rising-edge clock
//           reset_n  in  asynchronous active-low reset; loads seed
//           seed     in  RNG_WIDTH seed; zero is replaced by 'hACE1
//           step     in  advance one state this cycle
//           value    out RNG_WIDTH current LFSR state
module lfsr_rng #(
  parameter int RNG_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [RNG_WIDTH-1:0] seed,
  input  logic                 step,
  output logic [RNG_WIDTH-1:0] value
);

  // Right-shifting Galois masks: bit (t-1) set for each polynomial tap t.
  // Widths outside the table fall back to the 16-bit mask and are not maximal.
  localparam logic [31:0] TAPS_TABLE =
    (RNG_WIDTH == 8)  ? 32'h0000_00B8 :
    (RNG_WIDTH == 9)  ? 32'h0000_0110 :
    (RNG_WIDTH == 10) ? 32'h0000_0240 :
    (RNG_WIDTH == 12) ? 32'h0000_0E08 :
    (RNG_WIDTH == 16) ? 32'h0000_B400 :
    (RNG_WIDTH == 20) ? 32'h0009_0000 :
    (RNG_WIDTH == 24) ? 32'h00E1_0000 :
    (RNG_WIDTH == 32) ? 32'h8020_0003 :
                        32'h0000_B400;
  localparam logic [RNG_WIDTH-1:0] TAPS = TAPS_TABLE[RNG_WIDTH-1:0];

  // an all-zero state would lock the LFSR up
  localparam logic [31:0]          FALLBACK_SEED32 = 32'h0000_ACE1;
  localparam logic [RNG_WIDTH-1:0] FALLBACK_SEED   = FALLBACK_SEED32[RNG_WIDTH-1:0];

  logic [RNG_WIDTH-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (step) begin
      state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= (seed == '0) ? FALLBACK_SEED : seed;
    end else begin
      state_q <= state_d;
    end
  end

  assign value = state_q;

endmodule

// File: rtl/card_shoe.sv
// rtl/card_shoe.sv - multi-deck blackjack shoe with in-place Fisher-Yates shuffle
//
// Purpose : holds NUM_DECKS*52 suited cards, deals without replacement and
//           reshuffles the whole shoe on request with a repeatable LFSR order.
// Ports   : clk, reset_n          clock, asynchronous active-low reset
//           seed                 LFSR seed, sampled while reset_n=0
//           shuffle_req          pulse: recollect and shuffle the whole shoe
//           deal_req             pulse: deal the next card
//           busy                 high while filling or shuffling
//           deal_valid           pulse: dealt_rank/suit/value are valid
//           dealt_rank/suit/value registered card (rank 1..13, bj value)
//           cards_left, empty, reshuffle_due  shoe depletion status
module card_shoe
  import card_pkg::*;
#(
  parameter  int NUM_DECKS = 1,
  parameter  int CUT_CARDS = 15,
  parameter  int RNG_WIDTH = 16,
  localparam int SHOE_SIZE = DECK_SIZE * NUM_DECKS,
  localparam int IW        = $clog2(SHOE_SIZE),
  localparam int CW        = $clog2(SHOE_SIZE + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [RNG_WIDTH-1:0] seed,
  input  logic                 shuffle_req,
  input  logic                 deal_req,
  output logic                 busy,
  output logic                 deal_valid,
  output logic [3:0]           dealt_rank,
  output logic [1:0]           dealt_suit,
  output logic [3:0]           dealt_value,
  output logic [CW-1:0]        cards_left,
  output logic                 empty,
  output logic                 reshuffle_due
);

  shoe_state_t   state_q, state_d;
  logic [IW-1:0] fill_idx_q, fill_idx_d;
  logic [3:0]    fill_rank_q, fill_rank_d;
  logic [1:0]    fill_suit_q, fill_suit_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] idx_i_q, idx_i_d;
  logic [IW-1:0] idx_j_q, idx_j_d;
  logic [CW-1:0] cards_left_q, cards_left_d;
  logic          deal_valid_q, deal_valid_d;
  logic [3:0]    dealt_rank_q, dealt_rank_d;
  logic [1:0]    dealt_suit_q, dealt_suit_d;
  logic [3:0]    dealt_value_q, dealt_value_d;
  logic          busy_q, busy_d;

  card_t mem_q [SHOE_SIZE];
  card_t deal_card, card_i, card_j;

  logic [RNG_WIDTH-1:0] rng_value;
  logic [IW-1:0]        pick_j;
  logic                 rng_step;
  logic                 idle, shuf_go, deal_go;
  logic                 unused_rng;

  lfsr_rng #(
    .RNG_WIDTH(RNG_WIDTH)
  ) u_rng (
    .clk    (clk),
    .reset_n(reset_n),
    .seed   (seed),
    .step   (rng_step),
    .value  (rng_value)
  );

  assign rng_step   = (state_q == ST_SH_PICK);
  assign pick_j     = rng_value[IW-1:0];
  assign unused_rng = ^rng_value;

  assign deal_card = mem_q[ptr_q];
  assign card_i    = mem_q[idx_i_q];
  assign card_j    = mem_q[idx_j_q];

  // DEAL only marks the cycle after a deal; it accepts requests exactly like READY
  assign idle    = (state_q == ST_READY) || (state_q == ST_DEAL);
  assign shuf_go = idle && shuffle_req;
  assign deal_go = idle && deal_req && !shuffle_req && (cards_left_q != '0);

  always_comb begin
    state_d       = state_q;
    fill_idx_d    = fill_idx_q;
    fill_rank_d   = fill_rank_q;
    fill_suit_d   = fill_suit_q;
    ptr_d         = ptr_q;
    idx_i_d       = idx_i_q;
    idx_j_d       = idx_j_q;
    cards_left_d  = cards_left_q;
    deal_valid_d  = 1'b0;
    dealt_rank_d  = dealt_rank_q;
    dealt_suit_d  = dealt_suit_q;
    dealt_value_d = dealt_value_q;

    unique case (state_q)
      ST_FILL: begin
        // rank/suit counters walk k%13 and (k%52)/13 without a divider
        fill_idx_d = fill_idx_q + 1'b1;
        if (fill_rank_q == 4'(RANKS - 1)) begin
          fill_rank_d = 4'd0;
          fill_suit_d = fill_suit_q + 1'b1;
        end else begin
          fill_rank_d = fill_rank_q + 4'd1;
        end
        if (fill_idx_q == IW'(SHOE_SIZE - 1)) begin
          state_d      = ST_READY;
          cards_left_d = CW'(SHOE_SIZE);
          ptr_d        = '0;
        end
      end

      ST_READY, ST_DEAL: begin
        state_d = ST_READY;
        if (shuf_go) begin
          state_d      = ST_SH_PICK;
          idx_i_d      = IW'(SHOE_SIZE - 1);
          ptr_d        = '0;
          cards_left_d = CW'(SHOE_SIZE);
        end else if (deal_go) begin
          state_d       = ST_DEAL;
          deal_valid_d  = 1'b1;
          dealt_rank_d  = deal_card.rank + 4'd1;
          dealt_suit_d  = deal_card.suit;
          dealt_value_d = bj_value(deal_card.rank);
          ptr_d         = ptr_q + 1'b1;
          cards_left_d  = cards_left_q - 1'b1;
        end
      end

      ST_SH_PICK: begin
        // rejection sampling keeps j uniform over 0..i
        if (pick_j <= idx_i_q) begin
          idx_j_d = pick_j;
          state_d = ST_SH_SWAP;
        end
      end

      ST_SH_SWAP: begin
        idx_i_d = idx_i_q - 1'b1;
        state_d = (idx_i_q == IW'(1)) ? ST_READY : ST_SH_PICK;
      end

      default: state_d = ST_FILL;
    endcase

    busy_d = (state_d == ST_FILL) || (state_d == ST_SH_PICK) || (state_d == ST_SH_SWAP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_FILL;
      fill_idx_q    <= '0;
      fill_rank_q   <= '0;
      fill_suit_q   <= '0;
      ptr_q         <= '0;
      idx_i_q       <= '0;
      idx_j_q       <= '0;
      cards_left_q  <= '0;
      deal_valid_q  <= 1'b0;
      dealt_rank_q  <= '0;
      dealt_suit_q  <= '0;
      dealt_value_q <= '0;
      busy_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      fill_idx_q    <= fill_idx_d;
      fill_rank_q   <= fill_rank_d;
      fill_suit_q   <= fill_suit_d;
      ptr_q         <= ptr_d;
      idx_i_q       <= idx_i_d;
      idx_j_q       <= idx_j_d;
      cards_left_q  <= cards_left_d;
      deal_valid_q  <= deal_valid_d;
      dealt_rank_q  <= dealt_rank_d;
      dealt_suit_q  <= dealt_suit_d;
      dealt_value_q <= dealt_value_d;
      busy_q        <= busy_d;
    end
  end

  // Card storage needs no reset: FILL rewrites every entry after reset.
  // With i==j both writes carry the same card, so the swap is a no-op.
  always_ff @(posedge clk) begin
    if (state_q == ST_FILL) begin
      mem_q[fill_idx_q] <= {fill_suit_q, fill_rank_q};
    end else if (state_q == ST_SH_SWAP) begin
      mem_q[idx_i_q] <= card_j;
      mem_q[idx_j_q] <= card_i;
    end
  end

  assign busy          = busy_q;
  assign deal_valid    = deal_valid_q;
  assign dealt_rank    = dealt_rank_q;
  assign dealt_suit    = dealt_suit_q;
  assign dealt_value   = dealt_value_q;
  assign cards_left    = cards_left_q;
  assign empty         = (cards_left_q == '0);
  assign reshuffle_due = (cards_left_q <= CW'(CUT_CARDS));

endmodule

// File: tb/tb_card_shoe.sv
// tb/tb_card_shoe.sv - self-checking bench for card_shoe (1-deck and 2-deck shoes)
module tb_card_shoe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        r1_n = 1'b1, sh1 = 1'b0, dr1 = 1'b0;
  logic [15:0] seed1 = 16'h0;
  logic        busy1, dv1, em1, rd1;
  logic [3:0]  rk1, vl1;
  logic [1:0]  st1;
  logic [5:0]  cl1;

  logic        r2_n = 1'b0, sh2 = 1'b0, dr2 = 1'b0;
  logic [15:0] seed2 = 16'h0;
  logic        busy2, dv2, em2, rd2;
  logic [3:0]  rk2, vl2;
  logic [1:0]  st2;
  logic [6:0]  cl2;

  card_shoe #(.NUM_DECKS(1), .CUT_CARDS(15), .RNG_WIDTH(16)) u_shoe1 (
    .clk(clk), .reset_n(r1_n), .seed(seed1), .shuffle_req(sh1), .deal_req(dr1),
    .busy(busy1), .deal_valid(dv1), .dealt_rank(rk1), .dealt_suit(st1),
    .dealt_value(vl1), .cards_left(cl1), .empty(em1), .reshuffle_due(rd1)
  );

  card_shoe #(.NUM_DECKS(2), .CUT_CARDS(15), .RNG_WIDTH(16)) u_shoe2 (
    .clk(clk), .reset_n(r2_n), .seed(seed2), .shuffle_req(sh2), .deal_req(dr2),
    .busy(busy2), .deal_valid(dv2), .dealt_rank(rk2), .dealt_suit(st2),
    .dealt_value(vl2), .cards_left(cl2), .empty(em2), .reshuffle_due(rd2)
  );

  int checks = 0;
  int errors = 0;

  // Reference shoe: card id c = suit*13 + rank0, kept as a plain array.
  int          m_n;
  logic [15:0] m_lfsr;
  int          m_deck [104];
  int          m_ptr;
  int          seq_first [104];

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    // x^16 + x^14 + x^13 + x^11 + 1
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic void model_reset(input int n, input logic [15:0] s);
    m_n    = n;
    m_lfsr = (s == 16'h0) ? 16'hACE1 : s;
    m_ptr  = 0;
    for (int k = 0; k < n; k++) m_deck[k] = k % 52;
  endfunction

  function automatic void model_shuffle();
    int mask = 1;
    while (mask < m_n) mask = mask * 2;
    mask = mask - 1;
    for (int i = m_n - 1; i >= 1; i--) begin
      int j;
      int t;
      j = int'(m_lfsr) & mask;
      m_lfsr = lfsr_next(m_lfsr);
      while (j > i) begin
        j = int'(m_lfsr) & mask;
        m_lfsr = lfsr_next(m_lfsr);
      end
      t = m_deck[i]; m_deck[i] = m_deck[j]; m_deck[j] = t;
    end
    m_ptr = 0;
  endfunction

  function automatic int model_deal();
    int c;
    c = m_deck[m_ptr];
    m_ptr++;
    return c;
  endfunction

  // {valid, suit, rank, value} expected for card id c
  function automatic logic [10:0] card_word(input int c);
    logic [3:0] r;
    r = 4'(c % 13 + 1);
    return {1'b1, 2'(c / 13), r, (r > 4'd10) ? 4'd10 : r};
  endfunction

  task automatic reset1(input logic [15:0] s);
    @(negedge clk);
    r1_n = 1'b0; seed1 = s; sh1 = 1'b0; dr1 = 1'b0;
    repeat (2) @(negedge clk);
    r1_n = 1'b1;
  endtask

  task automatic wait_idle1(output int n);
    n = 0;
    while (busy1 === 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic pulse_deal1();
    @(negedge clk); dr1 = 1'b1;
    @(negedge clk); dr1 = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    @(negedge clk);
    seed1 = 16'h1234; r1_n = 1'b0;
    #1;
    checks++;
    if ({busy1, dv1, em1, cl1} !== {1'b1, 1'b0, 1'b1, 6'd0}) begin
      errors++;
      $display("FAIL reset_flags busy=%b valid=%b empty=%b left=%0d required 1 0 1 0", busy1, dv1, em1, cl1);
    end
    checks++;
    if ({rk1, st1, vl1} !== 10'd0) begin
      errors++;
      $display("FAIL reset_dealt rank=%0d suit=%0d value=%0d required 0 0 0", rk1, st1, vl1);
    end
    repeat (2) @(negedge clk);
    r1_n = 1'b1;
    wait_idle1(n);
    checks++;
    if (n != 52) begin
      errors++;
      $display("FAIL fill_cycles got %0d required 52", n);
    end
    checks++;
    if ({cl1, em1, rd1, dv1} !== {6'd52, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL ready_state left=%0d empty=%b due=%b valid=%b required 52 0 0 0", cl1, em1, rd1, dv1);
    end
    model_reset(52, 16'h1234);
  endtask

  task automatic test_fill_order();
    int c;
    @(negedge clk); dr1 = 1'b1;
    for (int k = 0; k < 52; k++) begin
      @(negedge clk);
      if (k == 51) dr1 = 1'b0;
      c = model_deal();
      checks++;
      if ({dv1, st1, rk1, vl1} !== card_word(c)) begin
        errors++;
        $display("FAIL fill_order card %0d got v=%b s=%0d r=%0d val=%0d required %h", k, dv1, st1, rk1, vl1, card_word(c));
      end
      if (k == 35) begin
        checks++;
        if (rd1 !== 1'b0 || cl1 !== 6'd16) begin
          errors++;
          $display("FAIL cut_before due=%b left=%0d required 0 16", rd1, cl1);
        end
      end
      if (k == 36) begin
        checks++;
        if (rd1 !== 1'b1 || cl1 !== 6'd15) begin
          errors++;
          $display("FAIL cut_at due=%b left=%0d required 1 15", rd1, cl1);
        end
      end
    end
    checks++;
    if (em1 !== 1'b1 || cl1 !== 6'd0) begin
      errors++;
      $display("FAIL empty_after_52 empty=%b left=%0d required 1 0", em1, cl1);
    end
  endtask

  task automatic test_empty_deal();
    pulse_deal1();
    checks++;
    if (dv1 !== 1'b0 || cl1 !== 6'd0 || em1 !== 1'b1) begin
      errors++;
      $display("FAIL deal_on_empty valid=%b left=%0d empty=%b required 0 0 1", dv1, cl1, em1);
    end
    @(negedge clk);
    checks++;
    if (dv1 !== 1'b0) begin
      errors++;
      $display("FAIL deal_on_empty_late valid=%b required 0", dv1);
    end
  endtask

  task automatic test_busy_ignore();
    int n;
    int seen;
    int c;
    seen = 0;
    reset1(16'h0BAD);
    dr1 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (dv1 === 1'b1) seen++;
    end
    dr1 = 1'b0;
    wait_idle1(n);
    checks++;
    if (seen != 0 || cl1 !== 6'd52 || n + 10 != 52) begin
      errors++;
      $display("FAIL busy_ignore valids=%0d left=%0d fill=%0d required 0 52 52", seen, cl1, n + 10);
    end
    model_reset(52, 16'h0BAD);
    pulse_deal1();
    c = model_deal();
    checks++;
    if ({dv1, st1, rk1, vl1} !== card_word(c)) begin
      errors++;
      $display("FAIL busy_ignore_first got s=%0d r=%0d required %h", st1, rk1, card_word(c));
    end
  endtask

  task automatic test_random_reshuffle();
    logic [15:0] s;
    int n;
    int c;
    int pre;
    for (int r = 0; r < 3; r++) begin
      s = (r == 0) ? 16'h0 : 16'($urandom_range(1, 65535));
      reset1(s);
      wait_idle1(n);
      model_reset(52, s);
      pre = $urandom_range(0, 20);
      for (int k = 0; k < pre; k++) begin
        pulse_deal1();
        c = model_deal();
        checks++;
        if ({dv1, st1, rk1, vl1} !== card_word(c)) begin
          errors++;
          $display("FAIL rand_pre seed=%h card %0d got s=%0d r=%0d required %h", s, k, st1, rk1, card_word(c));
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      for (int pass = 0; pass < 2; pass++) begin
        @(negedge clk); sh1 = 1'b1;
        @(negedge clk); sh1 = 1'b0;
        checks++;
        if (busy1 !== 1'b1 || cl1 !== 6'd52 || dv1 !== 1'b0) begin
          errors++;
          $display("FAIL shuffle_start busy=%b left=%0d valid=%b required 1 52 0", busy1, cl1, dv1);
        end
        sh1 = 1'b1;
        @(negedge clk); sh1 = 1'b0;
        wait_idle1(n);
        checks++;
        if (busy1 !== 1'b0) begin
          errors++;
          $display("FAIL shuffle_timeout busy=%b after %0d cycles required 0", busy1, n);
        end
        model_shuffle();
        for (int k = 0; k < ((pass == 0) ? 52 : 10); k++) begin
          pulse_deal1();
          c = model_deal();
          checks++;
          if ({dv1, st1, rk1, vl1} !== card_word(c)) begin
            errors++;
            $display("FAIL rand_shuffled seed=%h pass %0d card %0d got s=%0d r=%0d val=%0d required %h", s, pass, k, st1, rk1, vl1, card_word(c));
          end
          repeat ($urandom_range(0, 1)) @(negedge clk);
        end
      end
    end
  endtask

  task automatic test_two_deck(input int run);
    int n;
    int c;
    int bad;
    int moved;
    int diff;
    int cnt [52];
    int seq [104];
    @(negedge clk);
    r2_n = 1'b0; seed2 = 16'h1234; sh2 = 1'b0; dr2 = 1'b0;
    repeat (2) @(negedge clk);
    r2_n = 1'b1;
    n = 0;
    while (busy2 === 1'b1 && n < 5000) begin @(negedge clk); n++; end
    checks++;
    if (n != 104 || cl2 !== 7'd104) begin
      errors++;
      $display("FAIL two_deck_fill cycles=%0d left=%0d required 104 104", n, cl2);
    end
    model_reset(104, 16'h1234);
    @(negedge clk); sh2 = 1'b1;
    @(negedge clk); sh2 = 1'b0;
    n = 0;
    while (busy2 === 1'b1 && n < 20000) begin @(negedge clk); n++; end
    checks++;
    if (busy2 !== 1'b0 || cl2 !== 7'd104) begin
      errors++;
      $display("FAIL two_deck_shuffle busy=%b left=%0d required 0 104", busy2, cl2);
    end
    model_shuffle();
    for (int k = 0; k < 52; k++) cnt[k] = 0;
    bad = 0; moved = 0; diff = 0;
    @(negedge clk); dr2 = 1'b1;
    for (int k = 0; k < 104; k++) begin
      @(negedge clk);
      if (k == 103) dr2 = 1'b0;
      c = model_deal();
      seq[k] = int'(st2) * 13 + int'(rk2) - 1;
      checks++;
      if ({dv2, st2, rk2, vl2} !== card_word(c)) begin
        errors++;
        $display("FAIL two_deck_card run %0d card %0d got s=%0d r=%0d val=%0d required %h", run, k, st2, rk2, vl2, card_word(c));
      end
      if (seq[k] >= 0 && seq[k] < 52) cnt[seq[k]]++;
      else bad++;
      if (seq[k] != k % 52) moved++;
      if (run == 1 && seq[k] != seq_first[k]) diff++;
    end
    for (int k = 0; k < 52; k++) if (cnt[k] != 2) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL two_deck_counts %0d cards not seen exactly twice required 0", bad);
    end
    checks++;
    if (moved == 0) begin
      errors++;
      $display("FAIL two_deck_order %0d positions moved required >0", moved);
    end
    checks++;
    if (em2 !== 1'b1 || cl2 !== 7'd0) begin
      errors++;
      $display("FAIL two_deck_empty empty=%b left=%0d required 1 0", em2, cl2);
    end
    if (run == 0) begin
      seq_first = seq;
    end else begin
      checks++;
      if (diff != 0) begin
        errors++;
        $display("FAIL two_deck_repeat %0d positions differ required 0", diff);
      end
    end
  endtask

  task automatic test_shuffle_deal_collision();
    int n;
    int c;
    reset1(16'h0055);
    wait_idle1(n);
    model_reset(52, 16'h0055);
    for (int k = 0; k < 3; k++) begin
      pulse_deal1();
      c = model_deal();
      checks++;
      if ({dv1, st1, rk1, vl1} !== card_word(c)) begin
        errors++;
        $display("FAIL collide_pre card %0d got s=%0d r=%0d required %h", k, st1, rk1, card_word(c));
      end
    end
    @(negedge clk); sh1 = 1'b1; dr1 = 1'b1;
    @(negedge clk); sh1 = 1'b0; dr1 = 1'b0;
    checks++;
    if (dv1 !== 1'b0 || busy1 !== 1'b1 || cl1 !== 6'd52) begin
      errors++;
      $display("FAIL collide valid=%b busy=%b left=%0d required 0 1 52", dv1, busy1, cl1);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy1 !== 1'b1) begin
      errors++;
      $display("FAIL still_shuffling busy=%b required 1", busy1);
    end
    #2 r1_n = 1'b0;
    #1;
    checks++;
    if ({busy1, dv1, em1, cl1, rk1, st1, vl1} !== {1'b1, 1'b0, 1'b1, 6'd0, 10'd0}) begin
      errors++;
      $display("FAIL reset_mid_shuffle busy=%b valid=%b empty=%b left=%0d r=%0d s=%0d val=%0d required 1 0 1 0 0 0 0",
               busy1, dv1, em1, cl1, rk1, st1, vl1);
    end
    @(negedge clk); r1_n = 1'b1;
    wait_idle1(n);
    checks++;
    if (n != 52 || cl1 !== 6'd52) begin
      errors++;
      $display("FAIL refill cycles=%0d left=%0d required 52 52", n, cl1);
    end
    model_reset(52, 16'h0055);
    pulse_deal1();
    c = model_deal();
    checks++;
    if ({dv1, st1, rk1, vl1} !== card_word(c)) begin
      errors++;
      $display("FAIL refill_first got s=%0d r=%0d val=%0d required %h", st1, rk1, vl1, card_word(c));
    end
  endtask

  initial begin
    test_reset();
    test_fill_order();
    test_empty_deal();
    test_busy_ignore();
    test_two_deck(0);
    test_two_deck(1);
    test_random_reshuffle();
    test_shuffle_deal_collision();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
